// File: rtl/rv_decode_stage.sv
// RV32I decode stage: splits instruction words into fields and immediate, registered toward execute.
// Latency: one cycle from input transfer to dec_valid_out. Optional skid entry under `DECODE_SKID_EN`.
// Backpressure: without skid, ready = !valid || dec_ready_in; with skid, ready is registered (skid empty).
module rv_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            instr_valid_in,
  output logic            instr_ready_out,
  input  logic            flush_in,
  output logic [6:0]      opcode_out,
  output logic [2:0]      funct3_out,
  output logic [6:0]      funct7_out,
  output logic [4:0]      rs1_addr_out,
  output logic [4:0]      rs2_addr_out,
  output logic [4:0]      rd_addr_out,
  output logic [XLEN-1:0] imm_value_out,
  output logic [XLEN-1:0] pc_co_out,
  output logic            illegal_out,
  output logic            dec_valid_out,
  input  logic            dec_ready_in
);

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } dec_t;

  dec_t dec_new;
  dec_t main_q;
  logic main_vld;
  logic in_xfer;
  logic out_xfer;

  // A word presented during a flush is dropped, so it never counts as a transfer.
  assign in_xfer  = instr_valid_in && instr_ready_out && !flush_in;
  assign out_xfer = main_vld && dec_ready_in;

  // Combinational decode of the incoming word: fields always extracted, immediate by format.
  always_comb begin
    dec_new         = '0;
    dec_new.opcode  = instr_in[6:0];
    dec_new.funct3  = instr_in[14:12];
    dec_new.funct7  = instr_in[31:25];
    dec_new.rs1     = instr_in[19:15];
    dec_new.rs2     = instr_in[24:20];
    dec_new.rd      = instr_in[11:7];
    dec_new.pc      = pc_in;
    dec_new.imm     = '0;
    dec_new.illegal = 1'b0;
    case (instr_in[6:0])
      7'h13, 7'h03, 7'h67:
        dec_new.imm = {{20{instr_in[31]}}, instr_in[31:20]};
      7'h23:
        dec_new.imm = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      7'h63:
        dec_new.imm = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                       instr_in[30:25], instr_in[11:8], 1'b0};
      7'h37, 7'h17:
        dec_new.imm = {instr_in[31:12], 12'b0};
      7'h6F:
        dec_new.imm = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                       instr_in[20], instr_in[30:21], 1'b0};
      7'h33: begin
        // Only add/sub and srl/sra have an alternate funct7 encoding.
        if (instr_in[31:25] != 7'h00 && instr_in[31:25] != 7'h20)
          dec_new.illegal = 1'b1;
        if (instr_in[31:25] == 7'h20 && instr_in[14:12] != 3'b000 &&
            instr_in[14:12] != 3'b101)
          dec_new.illegal = 1'b1;
      end
      default:
        dec_new.illegal = 1'b1;
    endcase
    // Compressed or reserved encodings are never supported.
    if (instr_in[1:0] != 2'b11)
      dec_new.illegal = 1'b1;
  end

`ifdef DECODE_SKID_EN
  dec_t skid_q;
  logic skid_vld;

  // Ready depends only on skid occupancy, cutting the path from dec_ready_in.
  assign instr_ready_out = !skid_vld;

  // Main/skid buffer: stalled arrivals park in skid and refill main on the next output transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush_in) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!main_vld) begin
      if (in_xfer) begin
        main_q   <= dec_new;
        main_vld <= 1'b1;
      end
    end else if (out_xfer) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        skid_vld <= 1'b0;
      end else if (in_xfer) begin
        main_q   <= dec_new;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_q   <= dec_new;
      skid_vld <= 1'b1;
    end
  end
`else
  // Single register: it can take a new word whenever it is empty or draining this cycle.
  assign instr_ready_out = !main_vld || dec_ready_in;

  // Output register: load on input transfer, empty on an output transfer with nothing behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld <= 1'b0;
      main_q   <= '0;
    end else if (flush_in) begin
      main_vld <= 1'b0;
    end else if (in_xfer) begin
      main_q   <= dec_new;
      main_vld <= 1'b1;
    end else if (out_xfer) begin
      main_vld <= 1'b0;
    end
  end
`endif

  assign opcode_out    = main_q.opcode;
  assign funct3_out    = main_q.funct3;
  assign funct7_out    = main_q.funct7;
  assign rs1_addr_out  = main_q.rs1;
  assign rs2_addr_out  = main_q.rs2;
  assign rd_addr_out   = main_q.rd;
  assign imm_value_out = main_q.imm;
  assign pc_co_out     = main_q.pc;
  assign illegal_out   = main_q.illegal;
  assign dec_valid_out = main_vld;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage: decode vectors, backpressure, flush and reset.
// Build with or without DECODE_SKID_EN; expected acceptance counts follow the macro.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        instr_valid_in;
  logic        instr_ready_out;
  logic        flush_in;
  logic [6:0]  opcode_out;
  logic [2:0]  funct3_out;
  logic [6:0]  funct7_out;
  logic [4:0]  rs1_addr_out;
  logic [4:0]  rs2_addr_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] imm_value_out;
  logic [31:0] pc_co_out;
  logic        illegal_out;
  logic        dec_valid_out;
  logic        dec_ready_in;

`ifdef DECODE_SKID_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 1;
`endif

  rv_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
    .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
    .flush_in(flush_in), .opcode_out(opcode_out), .funct3_out(funct3_out),
    .funct7_out(funct7_out), .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out),
    .rd_addr_out(rd_addr_out), .imm_value_out(imm_value_out), .pc_co_out(pc_co_out),
    .illegal_out(illegal_out), .dec_valid_out(dec_valid_out), .dec_ready_in(dec_ready_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[14];
  logic [31:0] words[4];
  logic [31:0] pcs[4];
  logic [31:0] got_pc[$];
  logic [31:0] got_rd[$];

  initial begin
    int sent;
    logic [95:0] exp_b;
    logic [95:0] act_b;

    vecs[0]  = '{32'h00500093, 32'h100, 7'h13, 3'd0, 7'h00, 5'd0,  5'd5,  5'd1,  32'h00000005, 1'b0};
    vecs[1]  = '{32'h407302B3, 32'h104, 7'h33, 3'd0, 7'h20, 5'd6,  5'd7,  5'd5,  32'h00000000, 1'b0};
    vecs[2]  = '{32'h40415193, 32'h108, 7'h13, 3'd5, 7'h20, 5'd2,  5'd4,  5'd3,  32'h00000404, 1'b0};
    vecs[3]  = '{32'hFFF08093, 32'h10C, 7'h13, 3'd0, 7'h7F, 5'd1,  5'd31, 5'd1,  32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{32'hFE000EE3, 32'h110, 7'h63, 3'd0, 7'h7F, 5'd0,  5'd0,  5'd29, 32'hFFFFFFFC, 1'b0};
    vecs[5]  = '{32'h123450B7, 32'h114, 7'h37, 3'd5, 7'h09, 5'd8,  5'd3,  5'd1,  32'h12345000, 1'b0};
    vecs[6]  = '{32'h0000000B, 32'h118, 7'h0B, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
    vecs[7]  = '{32'h02000033, 32'h11C, 7'h33, 3'd0, 7'h01, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
    vecs[8]  = '{32'h00112623, 32'h120, 7'h23, 3'd2, 7'h00, 5'd2,  5'd1,  5'd12, 32'h0000000C, 1'b0};
    vecs[9]  = '{32'h008000EF, 32'h124, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd8,  5'd1,  32'h00000008, 1'b0};
    vecs[10] = '{32'h00000073, 32'h128, 7'h73, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
    vecs[11] = '{32'h40000033, 32'h12C, 7'h33, 3'd0, 7'h20, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0};
    vecs[12] = '{32'h40001033, 32'h130, 7'h33, 3'd1, 7'h20, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
    vecs[13] = '{32'h00001117, 32'h134, 7'h17, 3'd1, 7'h00, 5'd0,  5'd0,  5'd2,  32'h00001000, 1'b0};

    for (int k = 0; k < 4; k++) begin
      words[k] = 32'h00500013 | (32'(k + 1) << 7);
      pcs[k]   = 32'h200 + 32'(4 * k);
    end

    // Reset state
    reset = 1'b1; flush_in = 1'b0; instr_valid_in = 1'b0; dec_ready_in = 1'b1;
    instr_in = 32'h0; pc_in = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 96'(dec_valid_out), 96'd0);
    check("reset_fields", {opcode_out, funct3_out, funct7_out, rs1_addr_out, rs2_addr_out,
          rd_addr_out, illegal_out}, 96'd0);
    check("reset_imm_pc", {imm_value_out, pc_co_out}, 96'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", 96'(instr_ready_out), 96'd1);

    // Decode table, one word per cycle, dec_ready_in high
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      instr_in = vecs[i].instr; pc_in = vecs[i].pc; instr_valid_in = 1'b1;
      @(posedge clk); #1;
      exp_b = {vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
               vecs[i].imm, vecs[i].ill};
      act_b = {opcode_out, funct3_out, funct7_out, rs1_addr_out, rs2_addr_out, rd_addr_out,
               imm_value_out, illegal_out};
      check($sformatf("vec%0d_valid", i), 96'(dec_valid_out), 96'd1);
      check($sformatf("vec%0d_bundle", i), act_b, exp_b);
      check($sformatf("vec%0d_pc", i), 96'(pc_co_out), 96'(vecs[i].pc));
    end
    @(negedge clk);
    instr_valid_in = 1'b0;
    @(posedge clk); #1;
    check("drained", 96'(dec_valid_out), 96'd0);

    // Backpressure: 3 stalled cycles while streaming 4 words, then release
    sent = 0;
    for (int cyc = 0; cyc < 40 && got_pc.size() < 4; cyc++) begin
      @(negedge clk);
      dec_ready_in   = (cyc >= 3);
      instr_valid_in = (sent < 4);
      instr_in       = (sent < 4) ? words[sent] : 32'h0;
      pc_in          = (sent < 4) ? pcs[sent] : 32'h0;
      #1;
      if (cyc >= 1 && cyc <= 3) begin
        check($sformatf("stall%0d_pc", cyc), 96'(pc_co_out), 96'(pcs[0]));
        check($sformatf("stall%0d_rd", cyc), 96'(rd_addr_out), 96'd1);
      end
      if (cyc == 2)
        check("stall_ready_low", 96'(instr_ready_out), 96'd0);
      if (instr_valid_in && instr_ready_out) sent++;
      if (cyc == 2)
        check("stall_accepted", 96'(sent), 96'(EXP_ACC));
      if (dec_valid_out && dec_ready_in) begin
        got_pc.push_back(pc_co_out);
        got_rd.push_back(32'(rd_addr_out));
      end
    end
    check("bp_count", 96'(got_pc.size()), 96'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < got_pc.size()) begin
        check($sformatf("bp_order%0d_pc", k), 96'(got_pc[k]), 96'(pcs[k]));
        check($sformatf("bp_order%0d_rd", k), 96'(got_rd[k]), 96'(k + 1));
      end
    end
    @(negedge clk);
    instr_valid_in = 1'b0; dec_ready_in = 1'b1;
    @(posedge clk); #1;
    check("bp_empty", 96'(dec_valid_out), 96'd0);

    // Flush with both entries occupied and a word presented
    @(negedge clk);
    dec_ready_in = 1'b0; instr_valid_in = 1'b1; instr_in = words[0]; pc_in = 32'h280;
    @(negedge clk);
    instr_in = words[1]; pc_in = 32'h284;
    @(negedge clk);
    flush_in = 1'b1; instr_in = words[2]; pc_in = 32'h288;
    @(posedge clk); #1;
    check("flush_valid", 96'(dec_valid_out), 96'd0);
    check("flush_ready", 96'(instr_ready_out), 96'd1);
    @(negedge clk);
    flush_in = 1'b0; dec_ready_in = 1'b1; instr_in = words[3]; pc_in = 32'h300;
    @(posedge clk); #1;
    check("post_flush_valid", 96'(dec_valid_out), 96'd1);
    check("post_flush_pc", 96'(pc_co_out), 96'h300);
    @(negedge clk);
    instr_valid_in = 1'b0;
    @(posedge clk); #1;
    check("post_flush_single", 96'(dec_valid_out), 96'd0);

    // Reset while a bundle is held: data outputs clear
    @(negedge clk);
    dec_ready_in = 1'b0; instr_valid_in = 1'b1; instr_in = 32'h123450B7; pc_in = 32'h400;
    @(posedge clk); #1;
    check("pre_reset_imm", 96'(imm_value_out), 96'h12345000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_valid", 96'(dec_valid_out), 96'd0);
    check("midreset_data", {imm_value_out, pc_co_out, 25'd0, opcode_out}, 96'd0);
    @(negedge clk);
    reset = 1'b0; instr_valid_in = 1'b0; dec_ready_in = 1'b1;
    @(posedge clk); #1;
    check("after_reset_empty", 96'(dec_valid_out), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

- Instruction decode pipeline stage for the RV32I core.
- Accepts fetched instruction words with their PC over a valid/ready handshake.
- Splits each word into the opcode, funct3, funct7, register indices and sign-extended immediate consumed by the ALU and register file.
- Presents the decoded bundle, registered, to the execute stage over a second valid/ready handshake; carries its own buffering and supports flush on taken branches.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- instr_in  input  32  instruction word from fetch.
- pc_in  input  32  PC of instr_in.
- instr_valid_in  input  1  fetch has a word.
- instr_ready_out  output  1  stage can accept a word.
- flush_in  input  1  discard all held and incoming instructions.
- opcode_out  output  7  instr[6:0].
- funct3_out  output  3  instr[14:12].
- funct7_out  output  7  instr[31:25].
- rs1_addr_out  output  5  instr[19:15].
- rs2_addr_out  output  5  instr[24:20].
- rd_addr_out  output  5  instr[11:7].
- imm_value_out  output  32  sign-extended immediate.
- pc_co_out  output  32  PC of the decoded instruction.
- illegal_out  output  1  decoded word is unsupported.
- dec_valid_out  output  1  decoded bundle valid.
- dec_ready_in  input  1  execute accepts the bundle.

## Operation
Handshakes:
- An input transfer occurs when instr_valid_in && instr_ready_out.
- An output transfer occurs when dec_valid_out && dec_ready_in.
- While dec_valid_out=1 and dec_ready_in=0, all decoded outputs hold stable.

Immediate formats, selected by opcode:
- I-type (0x13, 0x03, 0x67): sign-extend instr[31:20].
- S-type (0x23): sign-extend {instr[31:25], instr[11:7]}.
- B-type (0x63): sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- U-type (0x37, 0x17): {instr[31:12], 12'b0}.
- J-type (0x6F): sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- R-type (0x33) and any other opcode: imm_value_out=0.

Field extraction:
- Every decoded field is extracted unconditionally, regardless of format.
- For I-type shifts, instr[31:25] appears both in funct7_out and in imm_value_out[11:5]; 0x20 there selects srai.

illegal_out=1 when any of the following holds:
- instr[1:0] != 2'b11.
- The opcode is outside the set above.
- Opcode 0x33 with funct7 not 0x00/0x20.
- Opcode 0x33 with funct7=0x20 and funct3 not 000/101.

An illegal word still transfers normally; execute decides the trap.

Flush:
- flush_in=1 drops all held entries.
- dec_valid_out=0 on the next cycle.
- Any word presented in the flush cycle is discarded, even if instr_ready_out=1.

Reset:
- Same effect as flush, plus every data output cleared to 0.
- Reset mid-transfer loses the in-flight word.

## Timing
- Reset values:
  - dec_valid_out=0, illegal_out=0.
  - All field outputs, imm_value_out and pc_co_out = 0.
  - instr_ready_out=1 from the first cycle after reset.
- Latency: a word accepted at edge N appears on the outputs with dec_valid_out=1 after edge N, i.e. one cycle.
- Throughput: one instruction per cycle when dec_ready_in is held high.
- Simultaneous input and output transfer on a full main register: the new bundle replaces the old one at the same edge.
- flush_in and reset take priority over any simultaneous transfer.

## Configuration
- DECODE_SKID_EN defined:
  - A two-entry buffer (main register plus skid register) is compiled in.
  - instr_ready_out is a registered signal: 1 while the skid entry is empty, with no combinational path from dec_ready_in.
  - A word accepted while the output stalls goes to the skid register.
  - The skid entry moves to the main register on the next output transfer.
- DECODE_SKID_EN undefined:
  - Single output register only.
  - instr_ready_out = !dec_valid_out || dec_ready_in, combinationally.

## Test plan
- Reset, then present 0x00500093 (addi x1,x0,5) at pc 0x100 → next cycle opcode 0x13, rd 1, rs1 0, imm 0x00000005, pc_co 0x100, illegal 0.
- Present 0x407302B3 (sub x5,x6,x7) → opcode 0x33, funct3 0, funct7 0x20, rs1 6, rs2 7, rd 5, imm 0. Then present 0x40415193 (srai x3,x2,4) → funct7 0x20, imm 0x00000404.
- Immediate extraction:
  - 0xFFF08093 → imm 0xFFFFFFFF.
  - 0xFE000EE3 (beq -4) → imm 0xFFFFFFFC.
  - 0x123450B7 (lui) → imm 0x12345000.
- Illegal detection:
  - 0x0000000B → illegal 1, dec_valid 1.
  - 0x02000033 (funct7 0x01) → illegal 1.
- Backpressure, both macro settings:
  - Hold dec_ready_in=0 for 3 cycles while streaming 4 words; outputs stay stable.
  - With DECODE_SKID_EN: exactly 2 words accepted, then instr_ready_out=0.
  - Without DECODE_SKID_EN: 1 word accepted.
  - Release dec_ready_in: all words emerge in order, none lost or duplicated.
- Flush while both entries are full and a word is presented → dec_valid_out=0 next cycle. The next accepted word is the first one emitted.
